// File: rtl/s2p_pkg.sv
// s2p_pkg: shared constants and types for the serial-to-parallel deserializer.
//   DefaultWidth  - default number of data bits per word
//   ParityBits    - extra frame bits appended after the data (1 with S2P_PARITY_EN)
//   bit_cnt_t     - bit-counter type, wide enough for the largest legal frame (17 bits)
//   frame_len()   - frame length in bits for a given data width
// Configuration macro: S2P_PARITY_EN (adds one even-parity bit per frame).
package s2p_pkg;

    localparam int unsigned DefaultWidth = 4;

`ifdef S2P_PARITY_EN
    localparam int unsigned ParityBits = 1;
`else
    localparam int unsigned ParityBits = 0;
`endif

    // Counts 0..16 at most (WIDTH=16 plus parity), so 5 bits always suffice.
    localparam int unsigned CntWidth = 5;
    typedef logic [CntWidth-1:0] bit_cnt_t;

    function automatic int unsigned frame_len(input int unsigned width);
        return width + ParityBits;
    endfunction

endpackage

// File: rtl/s2p_shift_reg.sv
// s2p_shift_reg: right-shifting register, new bits enter at the MSB.
// Ports:
//   clk     - clock, state updates on posedge
//   reset   - synchronous active-high reset (clears the register)
//   en_i    - shift bit_i in this cycle
//   clr_i   - zero the register this cycle (wins over en_i)
//   bit_i   - bit shifted in at the MSB
//   q_o     - register contents; the first bit shifted lands at bit 0 after WIDTH shifts
module s2p_shift_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (clr_i) begin
            shift_d = '0;
        end else if (en_i) begin
            shift_d = {bit_i, shift_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q_o = shift_q;

endmodule

// File: rtl/serial_to_parallel_deserializer.sv
// serial_to_parallel_deserializer: assembles LSB-first serial bits into WIDTH-bit words and
// presents them through a valid/ready output register.
// Ports:
//   clk          - clock, all state updates on posedge
//   reset        - synchronous active-high reset
//   serial_i     - serial data bit, LSB first
//   bit_valid_i  - serial_i carries a valid bit this cycle
//   abort_i      - discard any partial word (wins over bit_valid_i)
//   ready_i      - consumer accepts parallel_o this cycle
//   parallel_o   - assembled word, bit 0 = first bit received
//   valid_o      - parallel_o holds an unconsumed word
//   empty_o      - no partial word in progress (bit count = 0)
//   overrun_o    - sticky: a completed word was dropped because the output was full
//   parity_err_o - parity result for the word in parallel_o
// Configuration macro: S2P_PARITY_EN appends one even-parity bit to every frame; without it
// parity_err_o is tied low.
module serial_to_parallel_deserializer
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             bit_valid_i,
    input  logic             abort_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             empty_o,
    output logic             overrun_o,
    output logic             parity_err_o
);

    localparam int unsigned FRAME   = frame_len(WIDTH);
    localparam bit_cnt_t    LastCnt = bit_cnt_t'(FRAME - 1);

    bit_cnt_t         cnt_q, cnt_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             perr_q, perr_d;

    logic             accept;
    logic             complete;
    logic             data_bit;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    assign accept   = bit_valid_i & ~abort_i;
    assign complete = accept & (cnt_q == LastCnt);

`ifdef S2P_PARITY_EN
    // The trailing parity bit is not stored; it is checked directly as it arrives.
    assign data_bit  = cnt_q < bit_cnt_t'(WIDTH);
    assign word      = sr_q;
    assign word_perr = (^sr_q) ^ serial_i;
`else
    // The final data bit bypasses the register so the word loads in its arrival cycle.
    logic unused_sr_lsb;
    assign unused_sr_lsb = sr_q[0];
    assign data_bit      = 1'b1;
    assign word          = {serial_i, sr_q[WIDTH-1:1]};
    assign word_perr     = 1'b0;
`endif

    s2p_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (accept & data_bit),
        .clr_i (abort_i | complete),
        .bit_i (serial_i),
        .q_o   (sr_q)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = complete ? '0 : cnt_q + bit_cnt_t'(1);
        end
    end

    always_comb begin
        par_d     = par_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            // Output slot is free if empty or being consumed this very cycle.
            if (!valid_q || ready_i) begin
                par_d   = word;
                perr_d  = word_perr;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            par_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign parallel_o   = par_q;
    assign valid_o      = valid_q;
    assign empty_o      = (cnt_q == '0);
    assign overrun_o    = overrun_q;
    assign parity_err_o = perr_q;

endmodule

// File: doc/serial_to_parallel_deserializer.md
SERIAL_TO_PARALLEL_DESERIALIZER -- requirements
Module: serial_to_parallel_deserializer

Interface
REQ-001 Parameter: WIDTH, 4, number of data bits per word (legal 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 Port: serial_i  input  1  serial data bit, LSB first.
REQ-005 Port: bit_valid_i  input  1  serial_i carries a valid bit this cycle.
REQ-006 Port: abort_i  input  1  discard any partially received word.
REQ-007 Port: ready_i  input  1  consumer accepts parallel_o this cycle.
REQ-008 Port: parallel_o  output  WIDTH  assembled word, bit 0 = first bit received.
REQ-009 Port: valid_o  output  1  parallel_o holds an unconsumed word.
REQ-010 Port: empty_o  output  1  no partial word in the shift register (bit count = 0).
REQ-011 Port: overrun_o  output  1  sticky; a completed word was dropped.
REQ-012 Port: parity_err_o  output  1  parity result of the word in parallel_o.

Function
REQ-013 Bit counter shall count 0..FRAME-1 (FRAME = WIDTH, or WIDTH+1 with parity) and advance only on cycles with bit_valid_i=1.
REQ-014 Each accepted bit shall shift in at the MSB of the shift register, shifting right, so the first bit lands at bit 0 after WIDTH data bits.
REQ-015 Cycles with bit_valid_i=0 mid-word shall hold counter and shift register unchanged (gaps of any length tolerated).
REQ-016 Word completion is the cycle the final frame bit is accepted; the word shall appear on parallel_o with valid_o=1 on the following cycle (latency 1 clock after last bit).
REQ-017 Counter shall wrap to 0 at completion; a new word's first bit may be accepted on the very next cycle (back-to-back, no dead cycle).
REQ-018 valid_o shall remain high and parallel_o stable until a cycle with valid_o=1 and ready_i=1; valid_o clears after that cycle unless a new word loads the same cycle.
REQ-019 Completion with valid_o=1 and ready_i=0: new word dropped, parallel_o unchanged, overrun_o set and held until reset.
REQ-020 Completion in the same cycle as a handshake (valid_o=1, ready_i=1): new word loads, valid_o stays 1, no overrun.
REQ-021 abort_i=1 shall zero counter and shift register the next cycle, take priority over bit_valid_i, and leave parallel_o/valid_o/overrun_o untouched.
REQ-022 empty_o shall be combinationally high exactly when the bit counter is 0.

Reset
REQ-023 On reset: counter=0, shift register=0, parallel_o=0, valid_o=0, empty_o=1, overrun_o=0, parity_err_o=0.
REQ-024 Reset mid-word shall discard the partial word; the first bit_valid_i after reset deasserts is bit 0 of a new word.

Configuration
REQ-025 Macro S2P_PARITY_EN defined: frame = WIDTH data bits + 1 even-parity bit; parity_err_o=1 with the loaded word when XOR of data and parity bit is 1; held with parallel_o.
REQ-026 Macro S2P_PARITY_EN undefined: frame = WIDTH bits, parity_err_o tied to 0.

Structure
REQ-027 Package s2p_pkg shall hold the default WIDTH constant, the FRAME-width computation and the bit-counter typedef.
REQ-028 One sub-module, s2p_shift_reg (enable, clear, shift-in), shall implement the shift register; counter, output register and handshake stay in the top.

Verification
REQ-029 Reset, then bits 0,1,0,1 on consecutive cycles with ready_i=1 -> parallel_o=4'hA, valid_o=1 one cycle after 4th bit, empty_o=1.
REQ-030 Bits of 4'h6 with 2-cycle gaps (bit_valid_i=0) between each -> parallel_o=4'h6; counter held during gaps, empty_o=0 throughout.
REQ-031 ready_i=0, send 4'h3 then 4'hC back-to-back -> parallel_o stays 4'h3, overrun_o=1; then ready_i=1 -> valid_o drops, overrun_o stays 1.
REQ-032 Send 4'h5 then 4'h9 with ready_i pulsed exactly in 4'h9's completion cycle -> parallel_o=4'h9, valid_o never drops, overrun_o=0.
REQ-033 Two bits of a word, then reset (or abort_i) -> empty_o=1; next 4 bits 1,1,1,1 -> parallel_o=4'hF.
REQ-034 With S2P_PARITY_EN: 4'h7 + parity 1 -> parity_err_o=0; 4'h7 + parity 0 -> parity_err_o=1; plus 32 random words from the team's parallel-to-serial transmitter in loopback -> every word matches.
